// File: rtl/output_match.sv
// Accepting-state lookup: a DEPTH-entry table of state codes scanned LANES entries per cycle.
// Define MATCH_COUNT_EN to add the saturating MATCH_CNT hit counter output.
module output_match #(
    parameter int unsigned STATE_W = 8,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LANES   = 4,
    parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLR,
    input  logic               WR_EN,
    input  logic [IDX_W-1:0]   WR_ADDR,
    input  logic [STATE_W-1:0] WR_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [STATE_W-1:0] STATE_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               MATCH,
    output logic [IDX_W-1:0]   MATCH_IDX,
    output logic               BUSY
`ifdef MATCH_COUNT_EN
    ,
    output logic [15:0]        MATCH_CNT
`endif
);

    localparam int unsigned GROUPS = (DEPTH + LANES - 1) / LANES;
    localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [STATE_W-1:0]   codes [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [STATE_W-1:0]   key, key_nxt;
    logic [GRP_W-1:0]     grp, grp_nxt;
    logic                 match_r, match_nxt;
    logic [IDX_W-1:0]     idx_r, idx_nxt;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;

    // Out-of-range addresses never equal any entry index, so they drop out naturally.
    always_ff @(posedge CLK) begin
        if (RST && !CLR && WR_EN) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (WR_ADDR == IDX_W'(e)) begin
                    codes[e] <= WR_DATA;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            valid <= '0;
        end else if (CLR) begin
            valid <= '0;
        end else if (WR_EN) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (WR_ADDR == IDX_W'(e)) begin
                    valid[e] <= 1'b1;
                end
            end
        end
    end

    // Only entries belonging to the current lane group may hit; the lowest one wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (!hit && valid[e] && (codes[e] == key) && (GRP_W'(e / LANES) == grp)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(e);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key;
        grp_nxt   = grp;
        match_nxt = match_r;
        idx_nxt   = idx_r;
        unique case (state)
            IDLE: begin
                if (IN_VALID) begin
                    key_nxt   = STATE_DATA;
                    grp_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    match_nxt = 1'b1;
                    idx_nxt   = hit_idx;
                    state_nxt = DONE;
                end else if (grp == LAST_GRP) begin
                    match_nxt = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    grp_nxt = grp + 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            key     <= '0;
            grp     <= '0;
            match_r <= 1'b0;
            idx_r   <= '0;
        end else begin
            key     <= key_nxt;
            grp     <= grp_nxt;
            match_r <= match_nxt;
            idx_r   <= idx_nxt;
        end
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign BUSY      = (state != IDLE);
    assign MATCH     = match_r;
    assign MATCH_IDX = idx_r;

`ifdef MATCH_COUNT_EN
    logic [15:0] match_cnt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            match_cnt <= '0;
        end else if (CLR) begin
            match_cnt <= '0;
        end else if ((state == DONE) && OUT_READY && match_r && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 16'd1;
        end
    end

    assign MATCH_CNT = match_cnt;
`endif

endmodule

// File: tb/tb_output_match.sv
// Scoreboard bench for output_match: a default instance (DEPTH=32) and a DEPTH=10 instance.
// Build with MATCH_COUNT_EN defined to also exercise the saturating hit counter.
module tb_output_match;

    typedef struct {
        int   id;
        logic m;
        int   idx;
        int   lat;
        int   acc;
    } exp_t;

    logic            CLK;
    logic            rst;
    logic [1:0]      clr, wr_en, in_valid, out_ready;
    logic [1:0][4:0] wr_addr;
    logic [1:0][7:0] wr_data, state_data;
    logic [1:0]      in_ready, out_valid, match, busy;
    logic [4:0]      midx0;
    logic [3:0]      midx1;
`ifdef MATCH_COUNT_EN
    logic [15:0]     cnt0, cnt1;
`endif

    int   n_chk, n_fail, cyc;
    exp_t sb[$];
    logic [7:0] m_code [2][32];
    bit         m_valid[2][32];
    bit   [1:0] in_done;
    logic       cur_m [2];
    int         cur_i [2];
    int         hs_cyc[2];
    int         last_acc[2];
    bit         rdy_rand;

    output_match u_dut0 (
        .CLK(CLK), .RST(rst), .CLR(clr[0]), .WR_EN(wr_en[0]), .WR_ADDR(wr_addr[0]),
        .WR_DATA(wr_data[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .STATE_DATA(state_data[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .MATCH(match[0]), .MATCH_IDX(midx0), .BUSY(busy[0])
`ifdef MATCH_COUNT_EN
        , .MATCH_CNT(cnt0)
`endif
    );

    output_match #(.DEPTH(10), .LANES(4)) u_dut10 (
        .CLK(CLK), .RST(rst), .CLR(clr[1]), .WR_EN(wr_en[1]), .WR_ADDR(wr_addr[1][3:0]),
        .WR_DATA(wr_data[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .STATE_DATA(state_data[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .MATCH(match[1]), .MATCH_IDX(midx1), .BUSY(busy[1])
`ifdef MATCH_COUNT_EN
        , .MATCH_CNT(cnt1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int depth_of(input int id);
        return (id == 0) ? 32 : 10;
    endfunction

    function automatic int get_idx(input int id);
        return (id == 0) ? int'(midx0) : int'(midx1);
    endfunction

    // Reference: lowest valid entry holding the key; hit in group i/4 shows after i/4+1 edges.
    function automatic exp_t predict(input int id, input logic [7:0] key);
        exp_t e;
        e.id  = id;
        e.m   = 1'b0;
        e.idx = 0;
        e.lat = (depth_of(id) + 3) / 4;
        e.acc = 0;
        for (int i = depth_of(id) - 1; i >= 0; i--) begin
            if (m_valid[id][i] && m_code[id][i] == key) begin
                e.m   = 1'b1;
                e.idx = i;
                e.lat = i / 4 + 1;
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL d%0d_%s: got %0h expected %0h (cycle %0d)", id, nm, act, exp, cyc);
        end
    endtask

    task automatic wr(input int id, input int addr, input logic [7:0] d);
        wr_en[id]   = 1'b1;
        wr_addr[id] = 5'(addr);
        wr_data[id] = d;
        @(negedge CLK);
        wr_en[id] = 1'b0;
        if (addr < depth_of(id)) begin
            m_code[id][addr]  = d;
            m_valid[id][addr] = 1'b1;
        end
    endtask

    task automatic do_clr(input int id);
        clr[id] = 1'b1;
        @(negedge CLK);
        clr[id] = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[id][i] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [7:0] key);
        exp_t e;
        int   n;
        n = 0;
        in_valid[id]   = 1'b1;
        state_data[id] = key;
        while (!in_ready[id] && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready[id]) begin
            chk("accept_timeout", id, 32'(in_ready[id]), 1);
            in_valid[id] = 1'b0;
            return;
        end
        e = predict(id, key);
        e.acc = cyc + 1;
        last_acc[id] = cyc + 1;
        sb.push_back(e);
        @(negedge CLK);
        in_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready[id]) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0 || !in_ready[id]) chk("idle_timeout", id, 32'(sb.size()), 0);
    endtask

    // Monitor: pops one expectation per result and checks it is held until the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            for (int id = 0; id < 2; id++) begin
                if (out_valid[id]) begin
                    if (!in_done[id]) begin
                        in_done[id] = 1'b1;
                        if (sb.size() == 0) begin
                            chk("unexpected_out_valid", id, 32'(out_valid[id]), 0);
                            cur_m[id] = match[id];
                            cur_i[id] = get_idx(id);
                        end else begin
                            e = sb.pop_front();
                            chk("dut_select", id, id, e.id);
                            chk("match", id, 32'(match[id]), 32'(e.m));
                            chk("match_idx", id, get_idx(id), e.idx);
                            chk("latency", id, cyc - e.acc, e.lat);
                            cur_m[id] = e.m;
                            cur_i[id] = e.idx;
                        end
                    end else begin
                        chk("hold_match", id, 32'(match[id]), 32'(cur_m[id]));
                        chk("hold_idx", id, get_idx(id), cur_i[id]);
                    end
                    if (out_ready[id] && rst) begin
                        in_done[id] = 1'b0;
                        hs_cyc[id]  = cyc + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (rdy_rand) out_ready = 2'($urandom_range(0, 3));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int r;
        n_chk = 0; n_fail = 0; cyc = 0; rdy_rand = 1'b0; in_done = '0;
        rst = 1'b0; clr = '0; wr_en = '0; in_valid = '0; out_ready = 2'b11;
        wr_addr = '0; wr_data = '0; state_data = '0;
        for (int i = 0; i < 32; i++) begin
            m_valid[0][i] = 1'b0; m_valid[1][i] = 1'b0;
        end
        repeat (3) @(negedge CLK);
        rst = 1'b1;
        for (int id = 0; id < 2; id++) begin
            chk("rst_in_ready", id, 32'(in_ready[id]), 1);
            chk("rst_out_valid", id, 32'(out_valid[id]), 0);
            chk("rst_busy", id, 32'(busy[id]), 0);
            chk("rst_match", id, 32'(match[id]), 0);
            chk("rst_idx", id, get_idx(id), 0);
        end

        // Single hit in group 1
        wr(0, 5, 8'h1A);
        issue(0, 8'h1A); wait_idle(0);

        // Lowest of two hits, then a full-depth miss
        do_clr(0);
        wr(0, 3, 8'h07); wr(0, 20, 8'h07);
        issue(0, 8'h07); wait_idle(0);
        issue(0, 8'h99); wait_idle(0);

        // Consumer stall with a second query waiting
        wr(0, 5, 8'h1A);
        out_ready[0] = 1'b0;
        issue(0, 8'h1A);
        fork
            issue(0, 8'h07);
            begin
                int n;
                n = 0;
                while (!out_valid[0] && n < 50) begin
                    @(negedge CLK);
                    n++;
                end
                chk("stall_reached", 0, 32'(out_valid[0]), 1);
                repeat (5) begin
                    @(negedge CLK);
                    chk("stall_in_ready", 0, 32'(in_ready[0]), 0);
                end
                out_ready[0] = 1'b1;
            end
        join
        chk("accept_after_hs", 0, last_acc[0] - hs_cyc[0], 1);
        wait_idle(0);

        // Non-power-of-two depth: last partial group and ignored addresses 10-11
        wr(1, 9, 8'h44); wr(1, 10, 8'h55); wr(1, 11, 8'h55);
        issue(1, 8'h44); wait_idle(1);
        issue(1, 8'h00); wait_idle(1);
        issue(1, 8'h55); wait_idle(1);

        // Randomized traffic with a random consumer
        rdy_rand = 1'b1;
        for (int id = 0; id < 2; id++) begin
            repeat (50) begin
                r = $urandom_range(0, 19);
                if (r == 0) do_clr(id);
                else if (r < 8) wr(id, (id == 0) ? $urandom_range(0, 31) : $urandom_range(0, 15),
                                   8'($urandom_range(0, 15)));
                else begin
                    issue(id, 8'($urandom_range(0, 15)));
                    wait_idle(id);
                end
            end
        end
        rdy_rand = 1'b0;
        @(negedge CLK);
        out_ready = 2'b11;

`ifdef MATCH_COUNT_EN
        wr(0, 5, 8'h1A);
        force u_dut0.match_cnt = 16'hFFFD;
        #1;
        release u_dut0.match_cnt;
        @(negedge CLK);
        issue(0, 8'h1A); wait_idle(0);
        chk("cnt_fffe", 0, 32'(cnt0), 32'hFFFE);
        issue(0, 8'h1A); wait_idle(0);
        chk("cnt_ffff", 0, 32'(cnt0), 32'hFFFF);
        issue(0, 8'h1A); wait_idle(0);
        chk("cnt_sat", 0, 32'(cnt0), 32'hFFFF);
        do_clr(0);
        chk("cnt_clr", 0, 32'(cnt0), 0);
`endif

        // CLR beats a simultaneous write during SCAN
        do_clr(0);
        wr(0, 2, 8'h55);
        issue(0, 8'hAA);
        clr[0] = 1'b1; wr_en[0] = 1'b1; wr_addr[0] = 5'd2; wr_data[0] = 8'h55;
        @(negedge CLK);
        clr[0] = 1'b0; wr_en[0] = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[0][i] = 1'b0;
        wait_idle(0);
        issue(0, 8'h55); wait_idle(0);

        // Reset in the middle of a scan aborts the query
        wr(0, 30, 8'h66);
        issue(0, 8'h66);
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        rst = 1'b1;
        sb.delete();
        in_done = '0;
        for (int i = 0; i < 32; i++) begin
            m_valid[0][i] = 1'b0; m_valid[1][i] = 1'b0;
        end
        for (int id = 0; id < 2; id++) begin
            chk("mid_rst_out_valid", id, 32'(out_valid[id]), 0);
            chk("mid_rst_busy", id, 32'(busy[id]), 0);
            chk("mid_rst_match", id, 32'(match[id]), 0);
            chk("mid_rst_idx", id, get_idx(id), 0);
        end
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (out_valid[0] || out_valid[1]) seen++;
        end
        chk("no_out_valid_after_rst", 0, seen, 0);
        issue(0, 8'h66); wait_idle(0);
        issue(0, 8'h55); wait_idle(0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", 0, 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/output_match.md
OUTPUT_MATCH -- requirements
Module: output_match

Interface
REQ-001 The module SHALL have parameter STATE_W, default 8, meaning the width of an automaton state code.
REQ-002 The module SHALL have parameter DEPTH, default 32, meaning the number of output-state table entries; DEPTH >= LANES.
REQ-003 The module SHALL have parameter LANES, default 4, meaning the number of table entries compared per cycle; power of 2.
REQ-004 The module SHALL have parameter IDX_W, default clog2(DEPTH), meaning the width of a table index.
REQ-005 The module SHALL have port CLK, input, 1, the single clock; all logic on rising edge.
REQ-006 The module SHALL have port RST, input, 1, the reset, synchronous and active-low.
REQ-007 The module SHALL have port CLR, input, 1, which clears all entry valid bits.
REQ-008 The module SHALL have port WR_EN, input, 1, the table write strobe.
REQ-009 The module SHALL have port WR_ADDR, input, IDX_W, the table write index.
REQ-010 The module SHALL have port WR_DATA, input, STATE_W, the accepting-state code to store.
REQ-011 The module SHALL have port IN_VALID, input, 1, qualifying STATE_DATA.
REQ-012 The module SHALL have port IN_READY, output, 1, meaning the block accepts a query.
REQ-013 The module SHALL have port STATE_DATA, input, STATE_W, the state code to test.
REQ-014 The module SHALL have port OUT_VALID, output, 1, meaning a result is available.
REQ-015 The module SHALL have port OUT_READY, input, 1, meaning the consumer takes the result.
REQ-016 The module SHALL have port MATCH, output, 1, meaning the query hit a valid entry.
REQ-017 The module SHALL have port MATCH_IDX, output, IDX_W, the lowest matching entry index, 0 on miss.
REQ-018 The module SHALL have port BUSY, output, 1, high while in SCAN or DONE.

Function
REQ-019 The module SHALL hold DEPTH entries of {valid, STATE_W code}; WR_EN writes WR_DATA to entry WR_ADDR and sets its valid bit at the clock edge; WR_ADDR >= DEPTH is ignored.
REQ-020 CLR SHALL clear every valid bit at the clock edge and SHALL win over a simultaneous WR_EN, dropping the write.
REQ-021 The FSM SHALL have states IDLE, SCAN and DONE; IN_READY = (state==IDLE); OUT_VALID = (state==DONE).
REQ-022 In IDLE, IN_VALID&IN_READY SHALL latch STATE_DATA, set group base g=0 and enter SCAN.
REQ-023 In each SCAN cycle, entries g*LANES..g*LANES+LANES-1 SHALL be compared against the latched code, with indices >= DEPTH and invalid entries never matching.
REQ-024 On a hit in SCAN, the module SHALL register MATCH=1 and MATCH_IDX=lowest hit index, then enter DONE.
REQ-025 With no hit in the last group (g = ceil(DEPTH/LANES)-1), the module SHALL register MATCH=0, MATCH_IDX=0 and enter DONE; otherwise g increments.
REQ-026 Latency SHALL be as follows: for a query accepted at edge E and a hit in group g, OUT_VALID is high after edge E+g+1; a miss raises OUT_VALID after edge E+ceil(DEPTH/LANES).
REQ-027 In DONE, MATCH and MATCH_IDX SHALL hold stable until OUT_READY; OUT_VALID&OUT_READY returns the FSM to IDLE, with no new query accepted in that same cycle.
REQ-028 A write or CLR during SCAN SHALL affect only comparisons in later cycles; a same-cycle compare uses the pre-edge table contents.
REQ-029 A query arriving during a stall SHALL be held off by IN_READY=0 and never dropped or overwritten.

Reset
REQ-030 RST=0 at an edge SHALL force IDLE, clear all valid bits, set MATCH=0, MATCH_IDX=0, OUT_VALID=0 and BUSY=0, and zero MATCH_CNT if present.
REQ-031 Reset mid-SCAN or in DONE SHALL abort the query without producing OUT_VALID; RST SHALL take priority over CLR, WR_EN and IN_VALID.

Configuration
REQ-032 With MATCH_COUNT_EN defined, the module SHALL add output MATCH_CNT [15:0], which increments on each OUT_VALID&OUT_READY&MATCH, saturates at 16'hFFFF and is zeroed by reset or CLR.
REQ-033 Without MATCH_COUNT_EN, the MATCH_CNT port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Defaults; write 8'h1A to entry 5; query 8'h1A accepted at edge E -> OUT_VALID after E+2, MATCH=1, MATCH_IDX=5.
REQ-035 Entries 3 and 20 both hold 8'h07; query 8'h07 -> MATCH_IDX=3 after E+1; query 8'h99 -> MATCH=0, MATCH_IDX=0, OUT_VALID after E+8.
REQ-036 Hold OUT_READY=0 for 5 cycles in DONE while IN_VALID=1 -> MATCH/MATCH_IDX stable, IN_READY=0, second query accepted only after handshake+1 cycle.
REQ-037 CLR together with WR_EN (addr 2) during SCAN, and RST=0 mid-SCAN -> entry 2 invalid; no OUT_VALID after reset; all outputs 0.
REQ-038 DEPTH=10, LANES=4, write 8'h44 to entry 9; query 8'h44 -> hit in group 2 (MATCH_IDX=9); query 8'h00 -> miss after 3 scan cycles; entries 10-11 never match.
REQ-039 With MATCH_COUNT_EN, preload MATCH_CNT near 16'hFFFF via 65535 hits (or force) and complete further hits -> MATCH_CNT holds 16'hFFFF; CLR -> 0.
